// File: rtl/hazard_tnew_tracker.sv
// hazard_tnew_tracker: tracks in-flight destination registers and Tnew, raises D-stage stalls
module hazard_tnew_tracker #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_RSA,
    input  logic [4:0] D_RTA,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_WA,
    input  logic [1:0] D_Tnew,
    input  logic       D_md_use,
    input  logic       D_md_start,
    input  logic       D_md_sel,
    output logic       stall,
    output logic [4:0] E_WA,
    output logic [4:0] M_WA,
    output logic [4:0] W_WA,
    output logic       E_ready,
    output logic       M_ready,
    output logic       md_busy
);
    localparam int MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MD_MAX + 1);

    logic [4:0]    e_wa_q, e_wa_d, m_wa_q, m_wa_d, w_wa_q, w_wa_d;
    logic [1:0]    e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
    logic          e_md_start_q, e_md_start_d, e_md_sel_q, e_md_sel_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic          rs_hazard, rt_hazard, md_hazard;

    // Register $0 is never a hazard; a Tuse of 3 can never be below a 2-bit Tnew
    assign rs_hazard = (D_RSA != 5'd0) &&
                       ((D_RSA == e_wa_q && D_Tuse_rs < e_tnew_q) ||
                        (D_RSA == m_wa_q && D_Tuse_rs < m_tnew_q));
    assign rt_hazard = (D_RTA != 5'd0) &&
                       ((D_RTA == e_wa_q && D_Tuse_rt < e_tnew_q) ||
                        (D_RTA == m_wa_q && D_Tuse_rt < m_tnew_q));
    assign md_busy   = (md_cnt_q != '0);
    assign md_hazard = D_md_use && (md_busy || e_md_start_q);
    assign stall     = rs_hazard | rt_hazard | md_hazard;

    assign E_WA    = e_wa_q;
    assign M_WA    = m_wa_q;
    assign W_WA    = w_wa_q;
    assign E_ready = (e_tnew_q == 2'd0);
    assign M_ready = (m_tnew_q == 2'd0);

    // Next state: advance pipeline, bubble E on stall, run the mult/div countdown
    always_comb begin
        w_wa_d       = m_wa_q;
        m_wa_d       = e_wa_q;
        m_tnew_d     = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
        e_wa_d       = stall ? 5'd0 : D_WA;
        e_tnew_d     = stall ? 2'd0 : D_Tnew;
        e_md_start_d = stall ? 1'b0 : D_md_start;
        e_md_sel_d   = stall ? 1'b0 : D_md_sel;
        md_cnt_d     = e_md_start_q ? (e_md_sel_q ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES))
                     : md_busy      ? md_cnt_q - CW'(1)
                     :                md_cnt_q;
    end

    // State registers with synchronous reset discarding all in-flight work
    always_ff @(posedge clk) begin
        if (reset) begin
            e_wa_q       <= '0;
            m_wa_q       <= '0;
            w_wa_q       <= '0;
            e_tnew_q     <= '0;
            m_tnew_q     <= '0;
            e_md_start_q <= 1'b0;
            e_md_sel_q   <= 1'b0;
            md_cnt_q     <= '0;
        end else begin
            e_wa_q       <= e_wa_d;
            m_wa_q       <= m_wa_d;
            w_wa_q       <= w_wa_d;
            e_tnew_q     <= e_tnew_d;
            m_tnew_q     <= m_tnew_d;
            e_md_start_q <= e_md_start_d;
            e_md_sel_q   <= e_md_sel_d;
            md_cnt_q     <= md_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_tnew_tracker.sv
// tb_hazard_tnew_tracker: directed-vector self-checking bench for hazard_tnew_tracker
module tb_hazard_tnew_tracker;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_RSA, D_RTA, D_WA;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic       D_md_use, D_md_start, D_md_sel;
    logic       stall, E_ready, M_ready, md_busy;
    logic [4:0] E_WA, M_WA, W_WA;
    int         n_chk = 0;
    int         n_fail = 0;

    hazard_tnew_tracker #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .D_RSA(D_RSA), .D_RTA(D_RTA), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_WA(D_WA), .D_Tnew(D_Tnew),
        .D_md_use(D_md_use), .D_md_start(D_md_start), .D_md_sel(D_md_sel),
        .stall(stall), .E_WA(E_WA), .M_WA(M_WA), .W_WA(W_WA),
        .E_ready(E_ready), .M_ready(M_ready), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_d();
        D_RSA = 0; D_RTA = 0; D_Tuse_rs = 3; D_Tuse_rt = 3;
        D_WA = 0; D_Tnew = 0; D_md_use = 0; D_md_start = 0; D_md_sel = 0;
    endtask

    task automatic do_reset();
        reset = 1; idle_d(); tick(); tick(); reset = 0;
    endtask

    task automatic md_run(input logic sel, input int busy_cycles);
        do_reset();
        D_md_use = 1; D_md_start = 1; D_md_sel = sel; #1;
        chk("md_issue_nostall", stall, 0);
        tick();
        D_md_start = 0; D_md_sel = 0;
        for (int i = 0; i <= busy_cycles; i++) begin
            #1;
            chk($sformatf("md%0d_stall_c%0d", sel, i), stall, 1);
            chk($sformatf("md%0d_busy_c%0d", sel, i), md_busy, (i != 0));
            tick();
        end
        chk($sformatf("md%0d_release_stall", sel), stall, 0);
        chk($sformatf("md%0d_release_busy", sel), md_busy, 0);
    endtask

    initial begin
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            D_RSA = 5'($urandom); D_RTA = 5'($urandom); D_WA = 5'($urandom);
            D_Tuse_rs = 2'($urandom); D_Tuse_rt = 2'($urandom); D_Tnew = 2'($urandom_range(0, 2));
            D_md_use = 1'($urandom); D_md_start = 1'($urandom); D_md_sel = 1'($urandom);
            tick();
        end
        chk("rst_E_WA", E_WA, 0);
        chk("rst_M_WA", M_WA, 0);
        chk("rst_W_WA", W_WA, 0);
        chk("rst_E_ready", E_ready, 1);
        chk("rst_M_ready", M_ready, 1);
        chk("rst_md_busy", md_busy, 0);
        idle_d(); #1;
        chk("rst_stall", stall, 0);
        reset = 0;

        // load-use with Tuse 0: two stall cycles
        D_WA = 8; D_Tnew = 2; #1;
        chk("lw_issue_stall", stall, 0);
        tick();
        chk("lw_E_WA", E_WA, 8);
        chk("lw_E_ready", E_ready, 0);
        idle_d(); D_RSA = 8; D_Tuse_rs = 0; D_WA = 10; D_Tnew = 1; #1;
        chk("lu_stall1", stall, 1);
        tick();
        chk("lu_bubble_E_WA", E_WA, 0);
        chk("lu_M_WA", M_WA, 8);
        chk("lu_M_ready", M_ready, 0);
        chk("lu_stall2", stall, 1);
        tick();
        chk("lu_W_WA", W_WA, 8);
        chk("lu_stall3", stall, 0);
        tick();
        chk("lu_consumer_E_WA", E_WA, 10);

        // load-use with Tuse 1: exactly one stall
        do_reset();
        D_WA = 9; D_Tnew = 2; tick();
        idle_d(); D_RTA = 9; D_Tuse_rt = 1; #1;
        chk("lu1_stall1", stall, 1);
        tick();
        chk("lu1_stall2", stall, 0);

        // ALU result to branch
        do_reset();
        D_WA = 5; D_Tnew = 1; tick();
        idle_d(); D_RTA = 5; D_Tuse_rt = 0; #1;
        chk("alu_stall", stall, 1);
        chk("alu_E_ready", E_ready, 0);
        tick();
        chk("alu_M_WA", M_WA, 5);
        chk("alu_M_ready", M_ready, 1);
        chk("alu_nostall", stall, 0);

        // $zero destination never hazards
        do_reset();
        D_WA = 0; D_Tnew = 2; tick();
        idle_d(); D_RSA = 0; D_Tuse_rs = 0; #1;
        chk("zero_nostall", stall, 0);

        // Tuse of 3 never stalls even against a fresh load
        do_reset();
        D_WA = 7; D_Tnew = 2; tick();
        idle_d(); D_RSA = 7; D_Tuse_rs = 3; #1;
        chk("never_use_nostall", stall, 0);

        md_run(1'b1, 10);
        md_run(1'b0, 5);

        // reset mid-divide
        do_reset();
        D_md_use = 1; D_md_start = 1; D_md_sel = 1; tick();
        D_md_start = 0; D_md_sel = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_div_busy", md_busy, 1);
        chk("mid_div_stall", stall, 1);
        reset = 1; tick(); reset = 0;
        chk("mid_rst_busy", md_busy, 0);
        chk("mid_rst_stall", stall, 0);
        tick();
        chk("mid_rst_mflo_go", stall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
